flow_ctrl_pause_gen: RTL and testbench

Generates outgoing Ethernet PAUSE (XOFF/XON) requests for the simple GEMAC. It watches receive-FIFO free space against host-programmed hysteresis thresholds and sends an XOFF request when space runs low. While congestion persists it refreshes the XOFF periodically; when space recovers it releases the link partner. It sits between the RX buffering and the MAC TX control path, which performs the request/acknowledge handshake and builds the actual PAUSE frame.

---
 rtl/flow_ctrl_pause_gen.sv | 199 +++++++++++++++++++
 tb/tb_flow_ctrl_pause_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_ctrl_pause_gen.sv
// ---------------------------------------------------------------------------
// flow_ctrl_pause_gen
//
// Generates outgoing Ethernet PAUSE (XOFF/XON) requests for the GEMAC TX
// control path. Receive-FIFO free space is compared against host-programmed
// hysteresis thresholds:
//   - space below pause_thresh  -> request an XOFF carrying pause_time quanta
//   - congestion persists       -> refresh the XOFF every refresh_time quanta
//   - space back at resume_thresh (or generation disabled) -> release partner
//
// The MAC owns the request/acknowledge handshake and builds the frame; this
// block only decides when a frame is needed and what quanta it carries.
// A raised request is always held until acknowledged.
//
// Build option:
//   FLOW_CTRL_XON_EN  defined   : resume sends an explicit zero-quanta PAUSE
//                                 (XON) before returning to IDLE.
//                     undefined : resume returns straight to IDLE and the
//                                 partner's pause simply times out.
// ---------------------------------------------------------------------------
module flow_ctrl_pause_gen (
   input  logic        tx_clk,
   input  logic        rst,
   input  logic        tx_pause_gen_en,
   input  logic [15:0] fifo_space,
   input  logic [15:0] pause_thresh,
   input  logic [15:0] resume_thresh,
   input  logic [15:0] pause_time,
   input  logic [15:0] refresh_time,
   output logic        pause_req,
   output logic [15:0] pause_time_req,
   input  logic        pause_ack,
   output logic        xoff_active
);

   // One pause quantum is 512 bit times, i.e. 64 clocks at 8 bits/clock,
   // so the refresh counter holds refresh_time scaled by 2^6.
   localparam int QUANTUM_SHIFT = 6;
   localparam int CNT_W         = 16 + QUANTUM_SHIFT;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_XOFF_REQ = 2'd1,
      ST_PAUSED   = 2'd2,
      ST_XON_REQ  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_refresh_cnt;
   logic [15:0]        r_pause_time_req;

   logic               w_congested;
   logic               w_recovered;
   logic               w_cnt_zero;
   logic               w_refresh_due;
   logic               w_ack;
   logic               w_load_xoff;
   logic               w_load_xon;
   logic               w_load_cnt;
   logic               w_dec_cnt;

   // ------------------------------------------------------------------------
   // Condition decode. Thresholds are live inputs and are compared every
   // cycle; sane hysteresis (resume_thresh > pause_thresh) is the host's job.
   // ------------------------------------------------------------------------
   assign w_congested   = (fifo_space < pause_thresh);
   assign w_recovered   = ~tx_pause_gen_en | (fifo_space >= resume_thresh);
   assign w_cnt_zero    = (r_refresh_cnt == '0);
   assign w_refresh_due = (refresh_time != 16'd0) & w_cnt_zero;

   // An acknowledge only counts while a request is actually being presented;
   // a stray pause_ack in IDLE or PAUSED is ignored.
   assign w_ack = pause_ack & pause_req;

   // State register: the only place the FSM state changes.
   always_ff @(posedge tx_clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block order.
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. PAUSED checks resume before refresh so that a
   // recovery coinciding with refresh expiry never sends a stale XOFF.
   always_comb begin
      // NOTE: default assignment first keeps this block free of latches
      // on paths where no branch below updates the next state.
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (tx_pause_gen_en && w_congested) begin
               w_state_next = ST_XOFF_REQ;
            end
         end
         ST_XOFF_REQ: begin
            // Loss of enable or a fifo_space change here is deliberately
            // ignored until the MAC accepts the request.
            if (w_ack) begin
               w_state_next = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (w_recovered) begin
`ifdef FLOW_CTRL_XON_EN
               w_state_next = ST_XON_REQ;
`else
               w_state_next = ST_IDLE;
`endif
            end else if (w_refresh_due) begin
               w_state_next = ST_XOFF_REQ;
            end
         end
         ST_XON_REQ: begin
            if (w_ack) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Output decode, taken purely from the state register so that the
   // request and status lines are glitch-free and input-independent.
   always_comb begin
      pause_req   = 1'b0;
      xoff_active = 1'b0;
      case (r_state)
         ST_XOFF_REQ: begin
            pause_req   = 1'b1;
            xoff_active = 1'b1;
         end
         ST_PAUSED: begin
            xoff_active = 1'b1;
         end
         ST_XON_REQ: begin
            pause_req   = 1'b1;
         end
         default: begin
            pause_req   = 1'b0;
            xoff_active = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Quanta field. Loaded only on entry to a request state, so it is stable
   // for the whole request and keeps its value once the request completes.
   // ------------------------------------------------------------------------
   assign w_load_xoff = (w_state_next == ST_XOFF_REQ) && (r_state != ST_XOFF_REQ);

`ifdef FLOW_CTRL_XON_EN
   assign w_load_xon  = (r_state == ST_PAUSED) && (w_state_next == ST_XON_REQ);
`else
   // Without XON support the field is never cleared after reset.
   assign w_load_xon  = 1'b0;
`endif

   // Latch the quanta value for each new request: pause_time for XOFF,
   // zero for XON.
   always_ff @(posedge tx_clk or posedge rst) begin
      if (rst) begin
         r_pause_time_req <= 16'd0;
      end else if (w_load_xoff) begin
         r_pause_time_req <= pause_time;
      end else if (w_load_xon) begin
         r_pause_time_req <= 16'd0;
      end
   end

   assign pause_time_req = r_pause_time_req;

   // ------------------------------------------------------------------------
   // Refresh counter. Loaded when an XOFF is acknowledged and counted down
   // while PAUSED; it saturates at zero. With load value 64*R at the ack
   // edge, zero is reached R*64 edges later and the refresh request rises
   // one edge after that.
   // ------------------------------------------------------------------------
   assign w_load_cnt = (r_state == ST_XOFF_REQ) && w_ack;
   assign w_dec_cnt  = (r_state == ST_PAUSED) && !w_recovered &&
                       !w_refresh_due && !w_cnt_zero;

   // Refresh interval countdown in clocks.
   always_ff @(posedge tx_clk or posedge rst) begin
      if (rst) begin
         r_refresh_cnt <= '0;
      end else if (w_load_cnt) begin
         r_refresh_cnt <= {refresh_time, {QUANTUM_SHIFT{1'b0}}};
      end else if (w_dec_cnt) begin
         r_refresh_cnt <= r_refresh_cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_flow_ctrl_pause_gen.sv
// ---------------------------------------------------------------------------
// Directed testbench for flow_ctrl_pause_gen. Expected values are written by
// hand from the intended behaviour; XON-specific expectations follow the
// FLOW_CTRL_XON_EN build option.
// ---------------------------------------------------------------------------
module tb_flow_ctrl_pause_gen;

   logic        tx_clk;
   logic        rst;
   logic        tx_pause_gen_en;
   logic [15:0] fifo_space;
   logic [15:0] pause_thresh;
   logic [15:0] resume_thresh;
   logic [15:0] pause_time;
   logic [15:0] refresh_time;
   logic        pause_req;
   logic [15:0] pause_time_req;
   logic        pause_ack;
   logic        xoff_active;

   int checks = 0;
   int errors = 0;

   flow_ctrl_pause_gen dut (
      .tx_clk          (tx_clk),
      .rst             (rst),
      .tx_pause_gen_en (tx_pause_gen_en),
      .fifo_space      (fifo_space),
      .pause_thresh    (pause_thresh),
      .resume_thresh   (resume_thresh),
      .pause_time      (pause_time),
      .refresh_time    (refresh_time),
      .pause_req       (pause_req),
      .pause_time_req  (pause_time_req),
      .pause_ack       (pause_ack),
      .xoff_active     (xoff_active)
   );

   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge tx_clk);
      #1;
   endtask

   initial begin
      int n;
      int held;

      rst             = 1'b1;
      tx_pause_gen_en = 1'b1;
      fifo_space      = 16'd150;
      pause_thresh    = 16'd100;
      resume_thresh   = 16'd200;
      pause_time      = 16'hFFFF;
      refresh_time    = 16'd0;
      pause_ack       = 1'b0;

      // ---- reset values
      step(2);
      check("rst_pause_req", 32'(pause_req), 32'd0);
      check("rst_time_req",  32'(pause_time_req), 32'd0);
      check("rst_xoff",      32'(xoff_active), 32'd0);
      rst = 1'b0;
      step(1);
      check("idle_no_req", 32'(pause_req), 32'd0);

      // ---- XOFF request: space drops 150 -> 50
      fifo_space   = 16'd50;
      refresh_time = 16'd2;
      step(1);
      check("xoff_req",      32'(pause_req), 32'd1);
      check("xoff_time",     32'(pause_time_req), 32'hFFFF);
      check("xoff_active",   32'(xoff_active), 32'd1);
      step(5);
      check("xoff_hold",     32'(pause_req), 32'd1);

      // ---- refresh: next request 129 cycles after the ack edge
      pause_ack = 1'b1;
      step(1);
      pause_ack = 1'b0;
      check("paused_req_low", 32'(pause_req), 32'd0);
      check("paused_xoff",    32'(xoff_active), 32'd1);
      n = 0;
      while (!pause_req && n < 200) begin
         step(1);
         n++;
      end
      check("refresh_interval", 32'(n), 32'd129);
      check("refresh_time",     32'(pause_time_req), 32'hFFFF);

      // ---- refresh disabled: no further request
      refresh_time = 16'd0;
      pause_ack    = 1'b1;
      step(1);
      pause_ack = 1'b0;
      held = 0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (pause_req) held++;
      end
      check("no_refresh_reqs", 32'(held), 32'd0);
      check("no_refresh_xoff", 32'(xoff_active), 32'd1);

      // ---- resume: space rises to 200
      fifo_space = 16'd200;
      step(1);
      check("resume_xoff", 32'(xoff_active), 32'd0);
`ifdef FLOW_CTRL_XON_EN
      check("xon_req",  32'(pause_req), 32'd1);
      check("xon_time", 32'(pause_time_req), 32'd0);
      pause_ack = 1'b1;
      step(1);
      pause_ack = 1'b0;
      check("xon_done", 32'(pause_req), 32'd0);
`else
      check("resume_no_req",  32'(pause_req), 32'd0);
      check("resume_time",    32'(pause_time_req), 32'hFFFF);
`endif

      // ---- disable during XOFF_REQ: request is not withdrawn
      pause_time = 16'h1234;
      fifo_space = 16'd50;
      step(1);
      check("dis_req",  32'(pause_req), 32'd1);
      check("dis_time", 32'(pause_time_req), 32'h1234);
      tx_pause_gen_en = 1'b0;
      step(3);
      check("dis_req_held", 32'(pause_req), 32'd1);
      pause_ack = 1'b1;
      step(1);
      pause_ack = 1'b0;
      check("dis_paused_req",  32'(pause_req), 32'd0);
      check("dis_paused_xoff", 32'(xoff_active), 32'd1);
      step(1);
      check("dis_release_xoff", 32'(xoff_active), 32'd0);
`ifdef FLOW_CTRL_XON_EN
      check("dis_xon_req",  32'(pause_req), 32'd1);
      check("dis_xon_time", 32'(pause_time_req), 32'd0);
      pause_ack = 1'b1;
      step(1);
      pause_ack = 1'b0;
`else
      check("dis_idle_req", 32'(pause_req), 32'd0);
`endif

      // ---- ack held low for 1000 cycles
      tx_pause_gen_en = 1'b1;
      step(1);
      check("long_req_start", 32'(pause_req), 32'd1);
      held = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (pause_req) held++;
      end
      check("long_req_held", 32'(held), 32'd1000);
      check("long_req_time", 32'(pause_time_req), 32'h1234);

      // ---- counter expiry coincides with resume: resume wins
      refresh_time = 16'd1;
      pause_ack    = 1'b1;
      step(1);
      pause_ack = 1'b0;
      step(64);
      check("sim_pre_req",  32'(pause_req), 32'd0);
      check("sim_pre_xoff", 32'(xoff_active), 32'd1);
      fifo_space = 16'd200;
      step(1);
      check("sim_xoff", 32'(xoff_active), 32'd0);
`ifdef FLOW_CTRL_XON_EN
      check("sim_xon_req",  32'(pause_req), 32'd1);
      check("sim_xon_time", 32'(pause_time_req), 32'd0);
      pause_ack = 1'b1;
      step(1);
      pause_ack = 1'b0;
`else
      check("sim_no_req",  32'(pause_req), 32'd0);
      check("sim_time",    32'(pause_time_req), 32'h1234);
`endif

      // ---- reset during XOFF_REQ
      refresh_time = 16'd0;
      fifo_space   = 16'd50;
      step(1);
      check("rx_req", 32'(pause_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rx_async_req",  32'(pause_req), 32'd0);
      check("rx_async_time", 32'(pause_time_req), 32'd0);
      check("rx_async_xoff", 32'(xoff_active), 32'd0);
      @(posedge tx_clk);
      #1 rst = 1'b0;

      // ---- reset during PAUSED
      step(1);
      check("rp_req", 32'(pause_req), 32'd1);
      pause_ack = 1'b1;
      step(1);
      pause_ack = 1'b0;
      check("rp_paused", 32'(xoff_active), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rp_async_req",  32'(pause_req), 32'd0);
      check("rp_async_time", 32'(pause_time_req), 32'd0);
      check("rp_async_xoff", 32'(xoff_active), 32'd0);
      fifo_space = 16'd150;
      @(posedge tx_clk);
      #1 rst = 1'b0;

      // ---- stray ack in IDLE has no effect
      pause_ack = 1'b1;
      step(3);
      check("stray_req",  32'(pause_req), 32'd0);
      check("stray_xoff", 32'(xoff_active), 32'd0);
      check("stray_time", 32'(pause_time_req), 32'd0);
      // Congestion arrives with ack already high: IDLE must still raise the
      // request rather than treat the ack as a completed handshake.
      fifo_space = 16'd50;
      step(1);
      check("stray_then_req", 32'(pause_req), 32'd1);
      check("stray_then_time", 32'(pause_time_req), 32'h1234);
      step(1);
      pause_ack = 1'b0;
      check("stray_then_paused", 32'(pause_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
